// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request channel.
// A request is accepted in IDLE, delayed WAIT_CYCLES wait states, then answered in
// RESP until the initiator consumes the response. Out-of-range word indices return
// an error without touching memory.
// Optional build macro MEM_RESPONDER_ALIGN_CHECK_EN: also flag requests whose byte
// address is not word aligned as errors (no access, normal latency).
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cap_write_q, cap_write_d;
    logic            cap_err_q, cap_err_d;
    logic [AW-1:0]   cap_idx_q, cap_idx_d;
    logic [DW-1:0]   cap_wdata_q, cap_wdata_d;

    logic            req_ready_d;
    logic            resp_valid_d;
    logic [DW-1:0]   resp_rdata_d;
    logic            resp_err_d;
    logic            busy_d;

    logic            range_err_c;
    logic            addr_err_c;
    logic            mem_we_c;

    logic [DW-1:0]   mem [DEPTH];

    // Word index beyond the array is an addressing error.
    assign range_err_c = (req_addr[31:2] >= IW'(DEPTH));

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    // Misaligned byte addresses are rejected as well.
    assign addr_err_c = range_err_c || (req_addr[1:0] != 2'b00);
`else
    // Byte offset is ignored; only the range check applies.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign addr_err_c      = range_err_c;
`endif

    // State, counter, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_write_q <= 1'b0;
            cap_err_q   <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_write_q <= cap_write_d;
            cap_err_q   <= cap_err_d;
            cap_idx_q   <= cap_idx_d;
            cap_wdata_q <= cap_wdata_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
            busy        <= busy_d;
        end
    end

    // Next-state, wait counting, memory access and response formation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_write_d  = cap_write_q;
        cap_err_d    = cap_err_q;
        cap_idx_d    = cap_idx_q;
        cap_wdata_d  = cap_wdata_q;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        mem_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                // req_ready is low in the first cycle after reset, so gate on it.
                if (req_ready && req_valid) begin
                    cap_write_d = req_write;
                    cap_err_d   = addr_err_c;
                    cap_idx_d   = req_addr[AW+1:2];
                    cap_wdata_d = req_wdata;
                    cnt_d       = CW'(WAIT_CYCLES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = cap_err_q;
                    resp_rdata_d = (cap_write_q || cap_err_q) ? '0 : mem[cap_idx_q];
                    mem_we_c     = cap_write_q && !cap_err_q;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = '0;
                resp_valid_d = 1'b0;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // Storage array; not cleared by reset, and a reset edge suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            mem[cap_idx_q] <= cap_wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table vectors, hand-written corner
// sequences and randomized transactions against a word-level reference model.
module tb_mem_responder;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 64;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        req_valid0, req_write0, resp_ready0;
    logic [31:0] req_addr0, req_wdata0;
    logic        req_ready0, resp_valid0, resp_err0, busy0;
    logic [31:0] resp_rdata0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [int unsigned];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        bit          pulse;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    mem_responder #(.WAIT_CYCLES(W), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .req_ready(req_ready0), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference behaviour: word-indexed store, range (and optional alignment) check.
    function automatic void model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err);
        int unsigned word;
        logic [1:0]  lsb;
        word  = int'(addr >> 2);
        lsb   = addr[1:0];
        err   = (word >= DEPTH) || (ALIGN && (lsb != 2'b00));
        rdata = 32'h0;
        if (!err) begin
            if (wr) ref_mem[word] = wdata;
            else    rdata = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
        end
    endfunction

    // One full transaction on the WAIT_CYCLES=2 instance, checking timing and payload.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold, input bit pulse);
        chk("pre_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        chk("acc_busy", 32'(busy), 32'(1));
        chk("acc_ready", 32'(req_ready), 32'(0));
        for (int i = 0; i <= int'(W); i++) begin
            chk("wait_valid", 32'(resp_valid), 32'(0));
            tick();
        end
        chk("resp_valid", 32'(resp_valid), 32'(1));
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
            end
            tick();
            req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
            chk("hold_valid", 32'(resp_valid), 32'(1));
            chk("hold_rdata", resp_rdata, exp_rdata);
            chk("hold_err", 32'(resp_err), 32'(exp_err));
            chk("hold_ready", 32'(req_ready), 32'(0));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("done_valid", 32'(resp_valid), 32'(0));
        chk("done_rdata", resp_rdata, 32'h0);
        chk("done_err", 32'(resp_err), 32'(0));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_ready", 32'(req_ready), 32'(1));
    endtask

    initial begin
        logic [31:0] m_rdata;
        logic        m_err;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned word;
        int unsigned sel;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; resp_ready0 = 1'b0;

        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 0, 1'b0, 32'h0,       1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,       32'h12345678, 1, 1'b0, 32'h0,       1'b0};
        vecs[3]  = '{1'b0, 32'h20,       32'h0,        5, 1'b1, 32'h12345678, 1'b0};
        vecs[4]  = '{1'b1, 32'h0,        32'h0BADF00D, 0, 1'b0, 32'h0,       1'b0};
        vecs[5]  = '{1'b0, 32'h100,      32'h0,        0, 1'b0, 32'h0,       1'b1};
        vecs[6]  = '{1'b1, 32'h100,      32'hFFFF0000, 2, 1'b0, 32'h0,       1'b1};
        vecs[7]  = '{1'b0, 32'h0,        32'h0,        0, 1'b0, 32'h0BADF00D, 1'b0};
        vecs[8]  = '{1'b1, 32'hFC,       32'hA5A5A5A5, 0, 1'b0, 32'h0,       1'b0};
        vecs[9]  = '{1'b0, 32'hFC,       32'h0,        0, 1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b0, 32'h22,       32'h0,        0, 1'b0, ALIGN ? 32'h0 : 32'h12345678, ALIGN};
        vecs[11] = '{1'b1, 32'h13,       32'h11223344, 0, 1'b0, 32'h0,       ALIGN};
        vecs[12] = '{1'b0, 32'h10,       32'h0,        0, 1'b0, ALIGN ? 32'hDEADBEEF : 32'h11223344, 1'b0};
        vecs[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,        1, 1'b0, 32'h0,       1'b1};

        // Reset state.
        @(negedge clk);
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_valid", 32'(resp_valid), 32'(0));
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        chk("rst_ready_pre", 32'(req_ready), 32'(0));
        tick();
        chk("rst_ready_rise", 32'(req_ready), 32'(1));
        chk("rst_ready_rise0", 32'(req_ready0), 32'(1));

        // Zero-wait instance: 1-cycle latency, back-to-back every 3 cycles.
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h4; req_wdata0 = 32'h600DCAFE; resp_ready0 = 1'b1;
        tick();
        chk("d0_acc_busy", 32'(busy0), 32'(1));
        chk("d0_acc_valid", 32'(resp_valid0), 32'(0));
        req_write0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("d0_valid", 32'(resp_valid0), 32'((i % 3) == 0));
            if ((i % 3) == 0) begin
                chk("d0_rdata", resp_rdata0, (i == 0) ? 32'h0 : 32'h600DCAFE);
                chk("d0_err", 32'(resp_err0), 32'(0));
            end
        end
        req_valid0 = 1'b0;

        // Directed vectors.
        for (int v = 0; v < 14; v++) begin
            model_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, m_rdata, m_err);
            do_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_err,
                   vecs[v].hold, vecs[v].pulse);
        end

        // Reset during WAIT of a write aborts it without touching memory.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        tick();
        chk("abort_in_wait", 32'(busy), 32'(1));
        reset = 1'b1;
        tick();
        chk("abort_valid", 32'(resp_valid), 32'(0));
        chk("abort_rdata", resp_rdata, 32'h0);
        chk("abort_err", 32'(resp_err), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ready", 32'(req_ready), 32'(0));
        reset = 1'b0;
        tick();
        chk("abort_ready_rise", 32'(req_ready), 32'(1));
        model_txn(1'b0, 32'h20, 32'h0, m_rdata, m_err);
        chk("abort_model", m_rdata, 32'h12345678);
        do_txn(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 0, 1'b0);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 60; t++) begin
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            sel   = $urandom_range(0, 9);
            if (sel == 0) begin
                word = DEPTH + $urandom_range(0, 1 << 20);
                addr = (32'(word) << 2) | 32'($urandom_range(0, 3));
            end else if (sel == 1) begin
                word = $urandom_range(0, DEPTH - 1);
                addr = (32'(word) << 2) | 32'($urandom_range(1, 3));
            end else begin
                word = $urandom_range(0, DEPTH - 1);
                addr = 32'(word) << 2;
            end
            if (!wr && word < DEPTH && !ref_mem.exists(word)) wr = 1'b1;
            model_txn(wr, addr, wdata, m_rdata, m_err);
            do_txn(wr, addr, wdata, m_rdata, m_err, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and memory access, range 0..15.
REQ-002 Parameter DEPTH, default 64: number of 32-bit words stored, power of two, 2..256.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req_valid  input  1  initiator (control unit) presents a memory request.
REQ-006 req_write  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-007 req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-008 req_wdata  input  32  write data; qualified by req_valid and req_write.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 resp_valid  output  1  response present on resp_rdata/resp_err.
REQ-011 resp_ready  input  1  initiator consumes the response this cycle.
REQ-012 resp_rdata  output  32  read data; 0 for writes and errored requests.
REQ-013 resp_err  output  1  request addressed an invalid location; no access performed.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; on req_valid=1, capture req_write/req_addr/req_wdata, load wait counter with WAIT_CYCLES, go to WAIT.
REQ-017 WAIT: req_ready=0; counter nonzero -> decrement and stay; counter zero -> perform access, register result, go to RESP.
REQ-018 Latency: the request accepted at edge k SHALL produce resp_valid=1 after edge k+WAIT_CYCLES+1.
REQ-019 RESP: resp_valid=1 with resp_rdata/resp_err held stable; resp_ready=1 -> go to IDLE; otherwise hold indefinitely.
REQ-020 A request is accepted only in IDLE; req_valid in WAIT or RESP SHALL be ignored, and the initiator holds it.
REQ-021 Back-to-back: after the RESP->IDLE edge, the next request is accepted no earlier than the following edge, giving a minimum of WAIT_CYCLES+3 cycles per transaction.
REQ-022 Read: resp_rdata = mem[word index]; write: mem[word index] = captured wdata, resp_rdata = 0.
REQ-023 Word index >= DEPTH: resp_err=1, resp_rdata=0, memory unchanged.
REQ-024 A read issued after a write to the same address SHALL return the newly written data.
REQ-025 resp_valid, resp_rdata and resp_err SHALL be 0 outside RESP.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and busy=0, aborting any transaction in flight.
REQ-027 A write aborted in WAIT SHALL NOT modify memory; memory contents are not cleared by reset.
REQ-028 While reset is high, req_ready=0; it rises on the first edge at which reset is low.

Configuration
REQ-029 Macro MEM_RESPONDER_ALIGN_CHECK_EN defined: a request with req_addr[1:0] != 0 completes with resp_err=1, resp_rdata=0 and no memory access, keeping normal latency.
REQ-030 Macro MEM_RESPONDER_ALIGN_CHECK_EN undefined: req_addr[1:0] is ignored and resp_err reflects only the range check.

Verification
REQ-031 WAIT_CYCLES=2: write addr 0x10 data 0xDEADBEEF at edge k -> resp_valid after edge k+3 with resp_err=0 and rdata=0; a following read of 0x10 -> rdata 0xDEADBEEF.
REQ-032 resp_ready held low 5 cycles during RESP -> resp_valid and rdata stable throughout; a req_valid pulse in that window is not accepted (req_ready=0).
REQ-033 DEPTH=64: read addr 0x100 (word 64) -> resp_err=1, rdata=0; write to 0x100 leaves words 0..63 unchanged.
REQ-034 Write 0x12345678 to 0x20; assert reset during WAIT of a write of 0xFFFFFFFF to 0x20 -> IDLE next edge, all outputs 0; a later read of 0x20 returns 0x12345678.
REQ-035 Read addr 0x22: with the macro defined -> resp_err=1; without it -> rdata = mem[8], resp_err=0.
REQ-036 WAIT_CYCLES=0: read accepted at edge k -> resp_valid after edge k+1; back-to-back reads complete every 3 cycles with resp_ready held at 1.
